imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface. The datapath only reads imem (A = PC, RD = instr).
//  This block fills imem before execution: it takes a byte stream with a valid/ready handshake,
//  assembles 32-bit big-endian words and writes them to consecutive word addresses.
//  It holds the CPU (PC/regfile enables) until the program is fully loaded.
// PARAMETERS
//  BASE_ADDR  32'h0  byte address of first instruction word (word-aligned)
//  MAX_WORDS  64     largest legal program length in words (imem depth)
// PORTS
//  clock        in   1   system clock, all state updates on posedge
//  reset        in   1   synchronous, active-high
//  start        in   1   1-cycle pulse: begin a new load
//  byte_valid   in   1   byte_data holds a valid byte
//  byte_data    in   8   stream byte
//  byte_ready   out  1   loader accepts byte this cycle (transfer = valid & ready)
//  imem_we      out  1   imem write enable, 1-cycle pulse per word
//  imem_addr    out  32  imem byte address of write
//  imem_wd      out  32  imem write data
//  cpu_hold     out  1   1 = CPU stalled (PC enable low)
//  done         out  1   load completed successfully
//  error        out  1   header word count exceeded MAX_WORDS
//  words_loaded out  16  number of words written in current load
// BEHAVIOUR
//  Stream format: 4-byte header N (word count, MSB first), then 4*N bytes, each word MSB first.
//  Reset: state IDLE; byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wd=0, cpu_hold=1,
//   done=0, error=0, words_loaded=0. Byte counter, word index and word count cleared.
//  States: IDLE, HDR, DATA, WRITE, DONE, ERR.
//  IDLE: byte_ready=0. start -> HDR. byte_valid is ignored.
//  HDR: byte_ready=1. Each transfer shifts the byte into N (N = {N[23:0], byte}).
//   On the 4th transfer: N==0 -> DONE; N>MAX_WORDS -> ERR; else -> DATA.
//  DATA: byte_ready=1. Transfers shift into a 32-bit word register.
//   On the 4th transfer -> WRITE in the next cycle.
//  WRITE: exactly 1 cycle. byte_ready=0, imem_we=1, imem_wd=assembled word,
//   imem_addr = BASE_ADDR + 4*idx. Address arithmetic is 32-bit and wraps mod 2^32.
//   idx and words_loaded increment at the end of the cycle.
//   If idx+1==N -> DONE, else -> DATA.
//  DONE: done=1, cpu_hold=0, byte_ready=0. start -> HDR: clears done/words_loaded, cpu_hold=1.
//  ERR: error=1, cpu_hold=1, byte_ready=0. Only start or reset leaves ERR.
//   start -> HDR clears error.
//  cpu_hold=1 in every state except DONE. The transition into DONE drops hold on the next cycle.
//  start while in HDR/DATA/WRITE is ignored; the load in progress continues.
//  Minimum per-word time: 5 cycles (4 byte transfers + WRITE). byte_valid may gap at any time.
//  The byte counter advances only on transfers; partial words are held across gaps.
//  imem_addr/imem_wd hold their last value when imem_we=0.
//  Reset mid-load: returns to IDLE, partial word discarded, no write issued.
//   Words already written remain in imem.
// TESTING
//  1. Reset, start, stream 00 00 00 02 | 24 08 00 05 | 8C 09 00 04
//     -> writes 0x24080005 @0x0, then 0x8C090004 @0x4. done=1, cpu_hold=0, words_loaded=2.
//  2. Header 00 00 00 00 -> DONE immediately after the 4th header byte, with no imem_we pulse.
//  3. Header 00 00 00 41 (65 > MAX_WORDS=64) -> error=1, cpu_hold=1, byte_ready=0, no writes.
//     Then start clears error.
//  4. N=1 with byte_valid dropped for 3 cycles after the 2nd data byte
//     -> word is assembled correctly and exactly one imem_we pulse occurs.
//  5. N=3, assert reset after the 2nd byte of word 1 -> IDLE, only word 0 written,
//     all outputs at reset values.
//  6. BASE_ADDR=32'hFFFF_FFFC, N=2 -> writes @0xFFFFFFFC, then @0x00000000 (wrap).

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input, imem write port and load status of the instruction-memory loader.
// slave is the loader's view; master is the view of whoever feeds bytes and watches the result.
interface imem_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wd,
        output cpu_hold, done, error, words_loaded
    );

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wd,
        input  cpu_hold, done, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader.
// The loader receives a big-endian word count N, followed by N big-endian words.
// It writes each word to the next consecutive imem word address.
// The CPU is held in stall until the whole program is in place.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 64
) (
    input logic          clock,
    input logic          reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  byte_cnt_reg;
    logic [31:0] count_reg;
    logic [31:0] word_reg;
    logic [31:0] addr_reg;
    logic [31:0] wd_reg;
    logic [15:0] idx_reg;
    logic [15:0] words_loaded_reg;

    logic        ready;
    logic        xfer;
    logic        last_byte;
    logic        load_start;
    logic [31:0] hdr_shift;
    logic [31:0] word_shift;
    logic [15:0] idx_plus1;

    // The FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic, handshake decode and shift-in values.
    always_comb begin
        ready      = (state_reg == HDR) || (state_reg == DATA);
        xfer       = bus.byte_valid && ready;
        last_byte  = xfer && (byte_cnt_reg == 2'd3);
        hdr_shift  = {count_reg[23:0], bus.byte_data};
        word_shift = {word_reg[23:0], bus.byte_data};
        idx_plus1  = idx_reg + 16'd1;
        // start is honoured only between loads; a load in flight runs to completion
        load_start = bus.start &&
                     ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.start) state_next = HDR;
            HDR:   if (last_byte) begin
                       if (hdr_shift == 32'd0)                 state_next = DONE;
                       else if (hdr_shift > 32'(MAX_WORDS))    state_next = ERR;
                       else                                    state_next = DATA;
                   end
            DATA:  if (last_byte) state_next = WRITE;
            WRITE: state_next = ({16'h0, idx_plus1} == count_reg) ? DONE : DATA;
            DONE:  if (bus.start) state_next = HDR;
            ERR:   if (bus.start) state_next = HDR;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: the header and word shift registers, the write address/data latch, and the counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt_reg     <= 2'd0;
            count_reg        <= 32'd0;
            word_reg         <= 32'd0;
            addr_reg         <= BASE_ADDR;
            wd_reg           <= 32'd0;
            idx_reg          <= 16'd0;
            words_loaded_reg <= 16'd0;
        end else begin
            if (load_start) begin
                byte_cnt_reg     <= 2'd0;
                count_reg        <= 32'd0;
                word_reg         <= 32'd0;
                idx_reg          <= 16'd0;
                words_loaded_reg <= 16'd0;
            end
            if (xfer) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                if (state_reg == HDR) count_reg <= hdr_shift;
                else                  word_reg  <= word_shift;
                // Latch address/data on the final byte so both stay stable outside the write pulse.
                if ((state_reg == DATA) && (byte_cnt_reg == 2'd3)) begin
                    addr_reg <= BASE_ADDR + {14'h0, idx_reg, 2'b00};
                    wd_reg   <= word_shift;
                end
            end
            if (state_reg == WRITE) begin
                idx_reg          <= idx_plus1;
                words_loaded_reg <= words_loaded_reg + 16'd1;
            end
        end
    end

    assign bus.byte_ready   = ready;
    assign bus.imem_we      = (state_reg == WRITE);
    assign bus.imem_addr    = addr_reg;
    assign bus.imem_wd      = wd_reg;
    assign bus.cpu_hold     = (state_reg != DONE);
    assign bus.done         = (state_reg == DONE);
    assign bus.error        = (state_reg == ERR);
    assign bus.words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader.
// The stimulus pushes each expected imem write into a queue.
// A monitor pops and compares an entry whenever imem_we is seen.
// A second instance, whose base address sits at the top of memory, exercises address wrap.
module tb_imem_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset;
    logic start1, start2, byte_valid, sel;
    logic [7:0] byte_data;

    int total = 0;
    int bad   = 0;

    wr_t q1[$];
    wr_t q2[$];

    imem_loader_if if1();
    imem_loader_if if2();

    assign if1.start      = start1;
    assign if1.byte_valid = byte_valid & ~sel;
    assign if1.byte_data  = byte_data;
    assign if2.start      = start2;
    assign if2.byte_valid = byte_valid & sel;
    assign if2.byte_data  = byte_data;

    imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(64)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(64)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (if2)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write-enable cycle must match the oldest expected write.
    always @(negedge clock) begin
        wr_t e;
        if (if1.imem_we === 1'b1) begin
            $display("write dut1 addr=%h data=%h", if1.imem_addr, if1.imem_wd);
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1_unexpected_write: got addr %h data %h expected none",
                         if1.imem_addr, if1.imem_wd);
            end else begin
                e = q1.pop_front();
                check("dut1_addr", if1.imem_addr, e.addr);
                check("dut1_data", if1.imem_wd, e.data);
            end
        end
        if (if2.imem_we === 1'b1) begin
            $display("write dut2 addr=%h data=%h", if2.imem_addr, if2.imem_wd);
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut2_unexpected_write: got addr %h data %h expected none",
                         if2.imem_addr, if2.imem_wd);
            end else begin
                e = q2.pop_front();
                check("dut2_addr", if2.imem_addr, e.addr);
                check("dut2_data", if2.imem_wd, e.data);
            end
        end
    end

    // Offer one byte; it returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        rdy        = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20; i++) begin
            rdy = sel ? if2.byte_ready : if1.byte_ready;
            if (rdy) break;
            @(negedge clock);
        end
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL byte_ready_timeout: got ready 0 expected 1 for byte %h", b);
        end else begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic pulse_start(input logic which);
        if (which) start2 = 1'b1;
        else       start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic d;
        d = 1'b0;
        byte_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d = sel ? if2.done : if1.done;
            if (d) break;
            @(negedge clock);
        end
        check(name, {31'h0, d}, 32'h1);
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] d);
        q1.push_back({a, d});
    endtask

    initial begin
        reset      = 1'b1;
        start1     = 1'b0;
        start2     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        sel        = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values
        check("rst_byte_ready", {31'h0, if1.byte_ready}, 32'h0);
        check("rst_imem_we", {31'h0, if1.imem_we}, 32'h0);
        check("rst_imem_addr", if1.imem_addr, 32'h0);
        check("rst_imem_wd", if1.imem_wd, 32'h0);
        check("rst_cpu_hold", {31'h0, if1.cpu_hold}, 32'h1);
        check("rst_done", {31'h0, if1.done}, 32'h0);
        check("rst_error", {31'h0, if1.error}, 32'h0);
        check("rst_words_loaded", {16'h0, if1.words_loaded}, 32'h0);
        check("rst_dut2_addr", if2.imem_addr, 32'hFFFF_FFFC);
        reset = 1'b0;
        @(negedge clock);

        // 1: two-word program
        push1(32'h0, 32'h2408_0005);
        push1(32'h4, 32'h8C09_0004);
        pulse_start(1'b0);
        foreach (byte_list1[i]) send_byte(byte_list1[i]);
        wait_done("t1_done");
        check("t1_cpu_hold", {31'h0, if1.cpu_hold}, 32'h0);
        check("t1_words_loaded", {16'h0, if1.words_loaded}, 32'h2);
        check("t1_byte_ready", {31'h0, if1.byte_ready}, 32'h0);
        check("t1_addr_hold", if1.imem_addr, 32'h4);
        check("t1_wd_hold", if1.imem_wd, 32'h8C09_0004);

        // 2: empty program finishes on the last header byte
        pulse_start(1'b0);
        check("t2_hold_reasserted", {31'h0, if1.cpu_hold}, 32'h1);
        check("t2_wl_cleared", {16'h0, if1.words_loaded}, 32'h0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        byte_valid = 1'b0;
        check("t2_done", {31'h0, if1.done}, 32'h1);
        check("t2_cpu_hold", {31'h0, if1.cpu_hold}, 32'h0);
        check("t2_words_loaded", {16'h0, if1.words_loaded}, 32'h0);

        // 3: oversize header, then start clears the error
        pulse_start(1'b0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h41);
        byte_valid = 1'b0;
        @(negedge clock);
        check("t3_error", {31'h0, if1.error}, 32'h1);
        check("t3_cpu_hold", {31'h0, if1.cpu_hold}, 32'h1);
        check("t3_byte_ready", {31'h0, if1.byte_ready}, 32'h0);
        check("t3_done", {31'h0, if1.done}, 32'h0);
        pulse_start(1'b0);
        check("t3_error_cleared", {31'h0, if1.error}, 32'h0);
        check("t3_hdr_ready", {31'h0, if1.byte_ready}, 32'h1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        byte_valid = 1'b0;
        check("t3_empty_done", {31'h0, if1.done}, 32'h1);

        // 4: one word with a 3-cycle gap after the second data byte
        push1(32'h0, 32'hDEAD_BEEF);
        pulse_start(1'b0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD);
        byte_valid = 1'b0;
        repeat (3) @(negedge clock);
        send_byte(8'hBE); send_byte(8'hEF);
        wait_done("t4_done");
        check("t4_words_loaded", {16'h0, if1.words_loaded}, 32'h1);

        // 5: reset partway through word 1 of a three-word load
        push1(32'h0, 32'h1122_3344);
        pulse_start(1'b0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        byte_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t5_byte_ready", {31'h0, if1.byte_ready}, 32'h0);
        check("t5_imem_addr", if1.imem_addr, 32'h0);
        check("t5_imem_wd", if1.imem_wd, 32'h0);
        check("t5_cpu_hold", {31'h0, if1.cpu_hold}, 32'h1);
        check("t5_done", {31'h0, if1.done}, 32'h0);
        check("t5_words_loaded", {16'h0, if1.words_loaded}, 32'h0);
        repeat (3) @(negedge clock);
        check("t5_idle_ready", {31'h0, if1.byte_ready}, 32'h0);

        // 6: address wrap from the top of memory
        sel = 1'b1;
        q2.push_back({32'hFFFF_FFFC, 32'hA1B2_C3D4});
        q2.push_back({32'h0000_0000, 32'h0102_0304});
        pulse_start(1'b1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_done("t6_done");
        check("t6_words_loaded", {16'h0, if2.words_loaded}, 32'h2);
        check("t6_dut1_idle", {31'h0, if1.done}, 32'h0);

        repeat (2) @(negedge clock);
        check("q1_drained", q1.size(), 32'h0);
        check("q2_drained", q2.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    logic [7:0] byte_list1 [12] = '{8'h00, 8'h00, 8'h00, 8'h02,
                                    8'h24, 8'h08, 8'h00, 8'h05,
                                    8'h8C, 8'h09, 8'h00, 8'h04};

endmodule
